// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_rr_arbiter_pkg;

    // Controller state encoding: one arbitration cycle, then a burst grant.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Beat counter width; MAX_BURST is capped at 255 so it never wraps.
    localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// Cyclic first-set search: lowest index at or after ptr (mod NUM_REQ) with req set.
// Latency: purely combinational.
// Backpressure: none; any = 0 when no request is set (idx then 0).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                idx = ID_W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready streams into one output.
// Latency: one IDLE arbitration cycle, then combinational pass-through of the granted stream.
// Backpressure: m_ready is routed to the granted s_ready only; a stall holds the grant.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SIZE      = 32,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      s_valid,
    output logic [NUM_REQ-1:0]      s_ready,
    input  logic [NUM_REQ*SIZE-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SIZE-1:0]         m_data,
    output logic [ID_W-1:0]         m_id,
    output logic                    busy
);

    localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]       LAST_IDX   = ID_W'(NUM_REQ - 1);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         gnt_q, gnt_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SIZE-1:0]         m_data_q;
    logic [ID_W-1:0]         m_id_q;
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;
    logic                    release_gnt;
    logic [ID_W-1:0]         gnt_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (s_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Pointer value after releasing the current grant, wrapping at NUM_REQ.
    assign gnt_next = (gnt_q == LAST_IDX) ? '0 : gnt_q + ID_W'(1);

    // State and grant bookkeeping; the output hold registers track what was last shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            m_data_q   <= '0;
            m_id_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            m_data_q   <= m_data;
            m_id_q     <= m_id;
        end
    end

    // Next-state logic and outputs: arbitrate in IDLE, pass the winner through in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        release_gnt = 1'b0;
        s_ready     = '0;
        m_valid     = 1'b0;
        m_data      = m_data_q;
        m_id        = m_id_q;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                busy           = 1'b1;
                m_valid        = s_valid[gnt_q];
                m_data         = s_data[int'(gnt_q)*SIZE +: SIZE];
                m_id           = gnt_q;
                s_ready[gnt_q] = m_ready;
                if (!s_valid[gnt_q]) begin
                    // Requester went quiet: give the slot to someone else.
                    release_gnt = 1'b1;
                end else if (m_ready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_q + BEAT_CNT_W'(1) == BURST_LAST) begin
                        release_gnt = 1'b1;
                    end
                end
                if (release_gnt) begin
                    state_d  = IDLE;
                    rr_ptr_d = gnt_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter with a grant-level reference model.
// Latency: n/a.
// Backpressure: driven directly through m_ready.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int SZ = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_valid = '0;
    logic [N-1:0]    s_ready;
    logic [N*SZ-1:0] s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [SZ-1:0]   m_data;
    logic [1:0]      m_id;
    logic            busy;

    stream_rr_arbiter #(
        .NUM_REQ   (N),
        .SIZE      (SZ),
        .MAX_BURST (MB),
        .ID_W      (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_id    (m_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Source generators: each requester emits tagged beats numbered by seq.
    int           seq[N];
    int           limit[N];
    int           recv_cnt[N];
    logic [N-1:0] en = '0;

    // Reference model: who owns the output, beats so far, rotation start.
    bit          mv = 1'b0;
    int          cur = -1;
    int          ptr = 0;
    int          beats = 0;
    int          last_id = 0;
    logic [31:0] last_data = '0;

    // Grant log written by the model.
    int lg_n = 0;
    int lg_id[32];
    int lg_start[32];
    int lg_end[32];
    int lg_beats[32];

    function automatic logic [31:0] mk(input int i, input int s);
        return {8'(i + 1), 24'(s)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_valid[i]          = en[i] && (seq[i] < limit[i]);
            s_data[i*SZ +: SZ]  = mk(i, seq[i]);
        end
    endtask

    // One clock: compare at the falling edge, advance sources after the rising edge.
    task automatic step();
        logic [N-1:0] hs;
        logic [N-1:0] e_sr;
        logic         e_mv;
        logic         e_busy;
        int           e_mid;
        logic [31:0]  e_md;
        @(negedge clk);
        cyc++;
        hs = s_valid & s_ready;
        if (mv) begin
            e_sr = '0;
            e_mv = 1'b0;
            e_busy = 1'b0;
            e_mid = last_id;
            e_md = last_data;
            if (cur >= 0) begin
                e_busy = 1'b1;
                e_mv   = s_valid[cur];
                e_mid  = cur;
                e_md   = mk(cur, seq[cur]);
                if (m_ready) e_sr[cur] = 1'b1;
            end
            chk("busy", 64'(busy), 64'(e_busy));
            chk("m_valid", 64'(m_valid), 64'(e_mv));
            chk("s_ready", 64'(s_ready), 64'(e_sr));
            chk("m_id", 64'(m_id), 64'(e_mid));
            chk("m_data", 64'(m_data), 64'(e_md));
            // Per-source ordering: the k-th beat out of source i must be its k-th beat.
            if (m_valid && m_ready) begin
                chk("sb_data", 64'(m_data), 64'(mk(int'(m_id), recv_cnt[m_id])));
                recv_cnt[m_id]++;
            end
            // Model advance.
            if (!rst) begin
                if (cur >= 0) begin
                    last_id   = cur;
                    last_data = e_md;
                    if (!s_valid[cur]) begin
                        lg_end[lg_n-1] = cyc; lg_beats[lg_n-1] = beats;
                        ptr = (cur + 1) % N; cur = -1;
                    end else if (m_ready) begin
                        beats++;
                        if (beats == MB) begin
                            lg_end[lg_n-1] = cyc; lg_beats[lg_n-1] = beats;
                            ptr = (cur + 1) % N; cur = -1;
                        end
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (cur < 0 && s_valid[(ptr + k) % N]) begin
                            cur   = (ptr + k) % N;
                            beats = 0;
                            if (lg_n < 32) begin
                                lg_id[lg_n] = cur; lg_start[lg_n] = cyc + 1;
                                lg_end[lg_n] = -1; lg_beats[lg_n] = -1;
                                lg_n++;
                            end
                        end
                    end
                end
            end
        end
        if (rst) begin
            mv = 1'b1; cur = -1; ptr = 0; beats = 0; last_id = 0; last_data = '0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_valid(input logic [N-1:0] m);
        en = m;
        drive();
    endtask

    task automatic do_reset();
        set_valid('0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        lg_n = 0;
    endtask

    initial begin
        int c0;
        int st;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; limit[i] = 1000000; recv_cnt[i] = 0;
        end
        drive();
        step();
        rst = 1'b0;
        step();

        // Single requester 2, continuous valid.
        do_reset();
        set_valid(4'b0100);
        c0 = cyc + 1;
        steps(12);
        set_valid('0);
        steps(3);
        chk("t1_id0", 64'(lg_id[0]), 64'd2);
        chk("t1_latency", 64'(lg_start[0] - c0), 64'd1);
        chk("t1_beats", 64'(lg_beats[0]), 64'd4);
        chk("t1_id1", 64'(lg_id[1]), 64'd2);
        chk("t1_gap", 64'(lg_start[1] - lg_end[0] - 1), 64'd1);

        // All four requesting continuously.
        do_reset();
        set_valid(4'b1111);
        steps(28);
        set_valid('0);
        steps(4);
        for (int g = 0; g < 5; g++) begin
            chk("t2_order", 64'(lg_id[g]), 64'(g % 4));
            chk("t2_beats", 64'(lg_beats[g]), 64'd4);
        end
        chk("t2_sixth", 64'(lg_id[5]), 64'd1);

        // Requester 1 sends two beats then drops valid.
        do_reset();
        limit[1] = seq[1] + 2;
        set_valid(4'b0010);
        steps(8);
        chk("t3_id", 64'(lg_id[0]), 64'd1);
        chk("t3_beats", 64'(lg_beats[0]), 64'd2);
        chk("t3_rel", 64'(lg_end[0] - lg_start[0]), 64'd2);
        chk("t3_ptr", 64'(ptr), 64'd2);
        limit[1] = 1000000;
        set_valid('0);
        steps(2);

        // Backpressure for 5 cycles after two beats of requester 0.
        do_reset();
        m_ready = 1'b1;
        set_valid(4'b1111);
        steps(3);
        m_ready = 1'b0;
        st = seq[0];
        steps(5);
        chk("t4_stall_data", 64'(m_data), 64'(mk(0, st)));
        chk("t4_stall_busy", 64'(busy), 64'd1);
        m_ready = 1'b1;
        steps(4);
        set_valid('0);
        steps(3);
        chk("t4_id", 64'(lg_id[0]), 64'd0);
        chk("t4_beats", 64'(lg_beats[0]), 64'd4);
        chk("t4_len", 64'(lg_end[0] - lg_start[0]), 64'd8);

        // Reset during beat 3 of requester 3.
        do_reset();
        set_valid(4'b1000);
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_sready", 64'(s_ready), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mvalid", 64'(m_valid), 64'd0);
        chk("t5_mid", 64'(m_id), 64'd0);
        set_valid(4'b1010);
        steps(8);
        set_valid('0);
        steps(4);
        chk("t5_first", 64'(lg_id[0]), 64'd3);
        chk("t5_next", 64'(lg_id[1]), 64'd1);

        // No beat lost or duplicated on any source.
        for (int i = 0; i < N; i++) chk("sb_count", 64'(recv_cnt[i]), 64'(seq[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
